// File: rtl/ntt_modred_pkg.sv
// ntt_modred_pkg
//   Shared constants and helpers for the Barrett reduction stage (modred_barrett).
//   - barrett_mu(q, k)     : MU = floor(2^(2k) / q), evaluated at elaboration time.
//   - modred_lat(lat)      : end-to-end latency of modred_barrett for a given intmul latency,
//                            so upstream schedulers can align to it.
//   - MODRED_LAT_DEFAULT   : latency for the default intmul latency of 4.
//   - modred_tag_t         : default-width sideband tag type.
package ntt_modred_pkg;

   localparam int unsigned MODRED_TAG_W = 8;

   typedef logic [MODRED_TAG_W-1:0] modred_tag_t;

   function automatic int unsigned barrett_mu(input int unsigned q, input int unsigned k);
      longint unsigned num;
      num = 64'd1 << (2 * k);
      return 32'(num / 64'(q));
   endfunction

   function automatic int unsigned modred_lat(input int unsigned intmul_lat);
      return 2 * intmul_lat + 3;
   endfunction

   localparam int unsigned MODRED_LAT_DEFAULT = modred_lat(4);

endpackage

// File: rtl/intmul.sv
// intmul
//   Pipelined unsigned multiplier, p = a * b, LAT register stages, no reset.
//   Ports:
//     clk  in   clock
//     a_i  in   LOG_A-bit operand
//     b_i  in   LOG_B-bit operand
//     p_o  out  (LOG_A+LOG_B)-bit product, LAT cycles after a_i/b_i
//   TYPE selects an implementation flavour ("", "fpga_auto", "fpga_lut", "fpga_dsp");
//   all flavours are behaviourally identical here.
module intmul #(
   parameter int unsigned LOG_A = 8,
   parameter int unsigned LOG_B = 8,
   parameter int unsigned LAT   = 1,
   parameter string       TYPE  = ""
) (
   input  logic                   clk,
   input  logic [LOG_A-1:0]       a_i,
   input  logic [LOG_B-1:0]       b_i,
   output logic [LOG_A+LOG_B-1:0] p_o
);

   localparam int unsigned PW = LOG_A + LOG_B;
   localparam int unsigned D  = (LAT < 1) ? 1 : LAT;

   if (LAT < 1) begin : g_err_lat
      $error("intmul: LAT must be >= 1");
   end

   if (!(TYPE == "" || TYPE == "fpga_auto" || TYPE == "fpga_lut" || TYPE == "fpga_dsp"))
   begin : g_err_type
      $error("intmul: unknown TYPE");
   end

   logic [PW-1:0] pipe_q [D];

   always_ff @(posedge clk) begin
      pipe_q[0] <= PW'(a_i) * PW'(b_i);
      for (int unsigned i = 1; i < D; i++) begin
         pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign p_o = pipe_q[D-1];

endmodule

// File: rtl/modred_barrett.sv
// modred_barrett
//   Fully pipelined Barrett reduction: out_r = in_x mod Q, one input per cycle, no
//   backpressure, latency L = 2*INTMUL_LAT + 3. Valid, tag and error flag travel with
//   each item at matched latency.
//   Ports:
//     clk        in   clock (rising edge)
//     rst_n      in   asynchronous active-low reset (valid/err pipe and outputs only)
//     in_valid   in   in_x/in_tag valid this cycle
//     in_x       in   2*LOG_Q-bit operand, in_x < Q*Q
//     in_tag     in   TAG_W-bit sideband
//     out_valid  out  out_r/out_tag/out_err valid
//     out_r      out  in_x mod Q
//     out_tag    out  in_tag of the same item
//     out_err    out  range violation flag
//   Optional feature macro MODRED_RANGE_CHECK_EN: when defined, out_err flags in_x >= Q*Q;
//   otherwise out_err is constant 0 and no comparator is built.
module modred_barrett
   import ntt_modred_pkg::*;
#(
   parameter int unsigned LOG_Q       = 14,
   parameter int unsigned Q           = 12289,
   parameter int unsigned INTMUL_LAT  = 4,
   parameter string       INTMUL_TYPE = "",
   parameter int unsigned TAG_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [2*LOG_Q-1:0] in_x,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   output logic [LOG_Q-1:0]   out_r,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_err
);

   localparam int unsigned K   = LOG_Q;
   localparam int unsigned LAT = (INTMUL_LAT < 1) ? 1 : INTMUL_LAT;
   localparam int unsigned L   = modred_lat(LAT);
   localparam int unsigned XD  = 2 * LAT;
   localparam int unsigned MU  = barrett_mu(Q, K);

   localparam logic [K:0]   MU_C = (K+1)'(MU);
   localparam logic [K-1:0] Q_K  = K'(Q);
   localparam logic [K+1:0] Q_R  = (K+2)'(Q);

   if (INTMUL_LAT < 1) begin : g_err_lat
      $error("modred_barrett: INTMUL_LAT must be >= 1");
   end

   if (64'(Q) <= (64'd1 << (LOG_Q - 1)) || 64'(Q) >= (64'd1 << LOG_Q)) begin : g_err_q
      $error("modred_barrett: Q must satisfy 2^(LOG_Q-1) < Q < 2^LOG_Q");
   end

   // Datapath (no reset)
   logic [2*K-1:0]   x_q;
   logic [K+1:0]     xd_q [XD];
   logic [2*K+1:0]   t;
   logic [K:0]       qh;
   logic [2*K+1:0]   p;
   logic [K+1:0]     r_q;
   logic [K+1:0]     c1;
   logic [K+1:0]     c2;
   logic [K-1:0]     out_r_d;
   logic [TAG_W-1:0] tag_q [L-1];

   // Control / outputs (reset)
   logic [L-1:0]     vld_q;
   logic [K-1:0]     out_r_q;
   logic [TAG_W-1:0] out_tag_q;

   // M1: t = (x >> (k-1)) * MU
   intmul #(
      .LOG_A (K + 1),
      .LOG_B (K + 1),
      .LAT   (LAT),
      .TYPE  (INTMUL_TYPE)
   ) u_mul_mu (
      .clk (clk),
      .a_i (x_q[2*K-1:K-1]),
      .b_i (MU_C),
      .p_o (t)
   );

   assign qh = t[2*K+1:K+1];

   // M2: p = qh * Q
   intmul #(
      .LOG_A (K + 2),
      .LOG_B (K),
      .LAT   (LAT),
      .TYPE  (INTMUL_TYPE)
   ) u_mul_q (
      .clk (clk),
      .a_i ({1'b0, qh}),
      .b_i (Q_K),
      .p_o (p)
   );

   // r < 3Q fits in k+2 bits, so only the low k+2 bits of x and p are needed.
   always_ff @(posedge clk) begin
      x_q     <= in_x;
      xd_q[0] <= x_q[K+1:0];
      for (int unsigned i = 1; i < XD; i++) begin
         xd_q[i] <= xd_q[i-1];
      end
      r_q      <= xd_q[XD-1] - p[K+1:0];
      tag_q[0] <= in_tag;
      for (int unsigned i = 1; i < L - 1; i++) begin
         tag_q[i] <= tag_q[i-1];
      end
   end

   always_comb begin
      c1      = (r_q >= Q_R) ? (r_q - Q_R) : r_q;
      c2      = (c1 >= Q_R) ? (c1 - Q_R) : c1;
      out_r_d = c2[K-1:0];
   end

   // vld_q[L-2] marks the item sitting in r_q (COR stage input).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q     <= '0;
         out_r_q   <= '0;
         out_tag_q <= '0;
      end else begin
         vld_q <= {vld_q[L-2:0], in_valid};
         if (vld_q[L-2]) begin
            out_r_q   <= out_r_d;
            out_tag_q <= tag_q[L-2];
         end
      end
   end

   assign out_valid = vld_q[L-1];
   assign out_r     = out_r_q;
   assign out_tag   = out_tag_q;

`ifdef MODRED_RANGE_CHECK_EN
   localparam logic [2*K-1:0] QQ = (2*K)'(64'(Q) * 64'(Q));

   logic [L-1:0] err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= '0;
      end else begin
         err_q <= {err_q[L-2:0], in_valid && (in_x >= QQ)};
      end
   end

   assign out_err = err_q[L-1];
`else
   assign out_err = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = ^{t[K:0], p[2*K+1:K+2], c2[K+1:K]};

endmodule
